// File: rtl/vector_store_serializer_if.sv
// Store-request and data-memory write handshake bundle for vector_store_serializer.
// master = requester/memory side, slave = serializer.
interface vector_store_serializer_if #(
    parameter int V  = 128,
    parameter int N  = 32,
    parameter int AW = 32
);
    localparam int LANES = V / N;

    logic             st_valid;
    logic             st_ready;
    logic [V-1:0]     st_vdata;
    logic [AW-1:0]    st_base_addr;
    logic [LANES-1:0] st_lane_mask;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [N-1:0]     mem_wd;
    logic             mem_ack;
    logic             busy;
    logic             done;

    modport master (
        output st_valid, st_vdata, st_base_addr, st_lane_mask, mem_ack,
        input  st_ready, mem_we, mem_addr, mem_wd, busy, done
    );

    modport slave (
        input  st_valid, st_vdata, st_base_addr, st_lane_mask, mem_ack,
        output st_ready, mem_we, mem_addr, mem_wd, busy, done
    );
endinterface

// File: rtl/vector_store_serializer.sv
// Writes one V-bit vector to data memory as LANES consecutive N-bit words, lane 0 first.
// Define VSTORE_LANE_MASK_EN to honour st_lane_mask (disabled lanes skipped in zero cycles).
module vector_store_serializer #(
    parameter int V  = 128,
    parameter int N  = 32,
    parameter int AW = 32
) (
    input logic clk,
    input logic rst,
    vector_store_serializer_if.slave bus
);
    localparam int LANES = V / N;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t        state;
    logic [LW-1:0] lane;
    logic [V-1:0]  vdata;
    logic [AW-1:0] base;

    logic          first_hit;
    logic [LW-1:0] first_lane;
    logic          next_hit;
    logic [LW-1:0] next_lane;

    function automatic logic [AW-1:0] offset(input logic [LW-1:0] l);
        offset = AW'(l) << 2;
    endfunction

`ifdef VSTORE_LANE_MASK_EN
    logic [LANES-1:0] mask;

    // Descending scan leaves the lowest qualifying index in the result.
    always_comb begin
        first_hit  = 1'b0;
        first_lane = '0;
        next_hit   = 1'b0;
        next_lane  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bus.st_lane_mask[i]) begin
                first_hit  = 1'b1;
                first_lane = LW'(i);
            end
            if (mask[i] && i > int'(lane)) begin
                next_hit  = 1'b1;
                next_lane = LW'(i);
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^bus.st_lane_mask;

    always_comb begin
        first_hit  = 1'b1;
        first_lane = '0;
        next_hit   = (int'(lane) != LANES - 1);
        next_lane  = LW'(int'(lane) + 1);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            lane         <= '0;
            vdata        <= '0;
            base         <= '0;
`ifdef VSTORE_LANE_MASK_EN
            mask         <= '0;
`endif
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wd   <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.st_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.st_valid) begin
                        vdata        <= bus.st_vdata;
                        base         <= bus.st_base_addr;
`ifdef VSTORE_LANE_MASK_EN
                        mask         <= bus.st_lane_mask;
`endif
                        bus.busy     <= 1'b1;
                        bus.st_ready <= 1'b0;
                        if (first_hit) begin
                            state        <= WRITE;
                            lane         <= first_lane;
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= bus.st_base_addr + offset(first_lane);
                            bus.mem_wd   <= bus.st_vdata[first_lane*N +: N];
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // Address/data only move on ack, so they stay put through stalls.
                    if (bus.mem_ack) begin
                        if (next_hit) begin
                            lane         <= next_lane;
                            bus.mem_addr <= base + offset(next_lane);
                            bus.mem_wd   <= vdata[next_lane*N +: N];
                        end else begin
                            state      <= DONE;
                            bus.mem_we <= 1'b0;
                            bus.done   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.done     <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.st_ready <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    bus.mem_we   <= 1'b0;
                    bus.done     <= 1'b0;
                    bus.busy     <= 1'b0;
                    bus.st_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_store_serializer.sv
// Scoreboard bench for vector_store_serializer: directed stores, expected writes
// queued at issue time and popped by a negedge monitor on every accepted write.
module tb_vector_store_serializer;
    localparam int V     = 128;
    localparam int N     = 32;
    localparam int AW    = 32;
    localparam int LANES = V / N;

    localparam logic [V-1:0] D1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [V-1:0] D2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [N-1:0]  wd;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vector_store_serializer_if #(.V(V), .N(N), .AW(AW)) bus ();

    vector_store_serializer #(.V(V), .N(N), .AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    wr_t exp_q[$];
    int  checks    = 0;
    int  errors    = 0;
    int  done_seen = 0;
    int  done_exp  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            if (bus.done) done_seen++;
            if (bus.mem_we && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             bus.mem_addr, bus.mem_wd);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 64'(bus.mem_addr), 64'(e.addr));
                    check("write_data", 64'(bus.mem_wd), 64'(e.wd));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input logic [V-1:0] d, input logic [AW-1:0] b,
                            input logic [LANES-1:0] m);
        wr_t e;
        for (int i = 0; i < LANES; i++) begin
`ifdef VSTORE_LANE_MASK_EN
            if (!m[i]) continue;
`endif
            e.addr = b + AW'(4 * i);
            e.wd   = d[i*N +: N];
            exp_q.push_back(e);
        end
        done_exp++;
    endtask

    // Returns in cycle 1 (the cycle after acceptance), #1 past the edge.
    task automatic send(input logic [V-1:0] d, input logic [AW-1:0] b,
                        input logic [LANES-1:0] m);
        bus.st_vdata      = d;
        bus.st_base_addr  = b;
        bus.st_lane_mask  = m;
        bus.st_valid      = 1'b1;
        for (int i = 0; i < 50 && !bus.st_ready; i++) step();
        if (!bus.st_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: st_ready %0b, expected 1", bus.st_ready);
        end
        step();
        bus.st_valid = 1'b0;
    endtask

    task automatic expect_done_at(input string name, input int start, input int want);
        int c;
        c = start;
        while (!bus.done && c < start + 40) begin
            step();
            c++;
        end
        check(name, 64'(c), 64'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid     = 1'b0;
        bus.st_vdata     = '0;
        bus.st_base_addr = '0;
        bus.st_lane_mask = '1;
        bus.mem_ack      = 1'b0;
        rst              = 1'b1;
        repeat (3) step();

        check("rst_ready", 64'(bus.st_ready), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_we", 64'(bus.mem_we), 64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_wd", 64'(bus.mem_wd), 64'd0);
        rst = 1'b0;
        step();

        // Basic store, ack tied high
        bus.mem_ack = 1'b1;
        push_vec(D1, 32'h100, 4'hF);
        send(D1, 32'h100, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            check("basic_we", 64'(bus.mem_we), 64'd1);
            step();
        end
        check("basic_done_c5", 64'(bus.done), 64'd1);
        check("basic_ready_c5", 64'(bus.st_ready), 64'd0);
        check("basic_we_c5", 64'(bus.mem_we), 64'd0);
        step();
        check("basic_ready_c6", 64'(bus.st_ready), 64'd1);
        check("basic_done_c6", 64'(bus.done), 64'd0);

        // Stall on lane 1 for 3 cycles
        push_vec(D1, 32'h100, 4'hF);
        send(D1, 32'h100, 4'hF);
        step();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.mem_ack = 1'b1;
            check("stall_addr", 64'(bus.mem_addr), 64'h104);
            check("stall_wd", 64'(bus.mem_wd), 64'h22222222);
            if (k < 3) step();
        end
        expect_done_at("stall_done_cycle", 5, 8);
        step();

        // Address wrap
        push_vec(D1, 32'hFFFF_FFF8, 4'hF);
        send(D1, 32'hFFFF_FFF8, 4'hF);
        expect_done_at("wrap_done_cycle", 1, 5);
        step();

        // Busy rejection: second request held from cycle 1
        push_vec(D1, 32'h300, 4'hF);
        push_vec(D2, 32'h400, 4'hF);
        send(D1, 32'h300, 4'hF);
        bus.st_vdata     = D2;
        bus.st_base_addr = 32'h400;
        bus.st_valid     = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check("busy_ready_low", 64'(bus.st_ready), 64'd0);
            if (k == 5) check("busy_first_done", 64'(bus.done), 64'd1);
            step();
        end
        check("busy_ready_c6", 64'(bus.st_ready), 64'd1);
        step();
        bus.st_valid = 1'b0;
        expect_done_at("busy_second_done", 7, 11);
        step();

        // Reset during lane-2 write
        begin
            wr_t e;
            e.addr = 32'h500; e.wd = D1[31:0];  exp_q.push_back(e);
            e.addr = 32'h504; e.wd = D1[63:32]; exp_q.push_back(e);
        end
        send(D1, 32'h500, 4'hF);
        step();
        step();
        check("rst_mid_lane2_addr", 64'(bus.mem_addr), 64'h508);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_we", 64'(bus.mem_we), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_ready", 64'(bus.st_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("rst_mid_no_done", 64'(bus.done), 64'd0);
            step();
        end

`ifdef VSTORE_LANE_MASK_EN
        push_vec(D1, 32'h200, 4'b1010);
        send(D1, 32'h200, 4'b1010);
        check("mask_c1_addr", 64'(bus.mem_addr), 64'h204);
        expect_done_at("mask_done_cycle", 1, 3);
        step();

        push_vec(D1, 32'h600, 4'b0000);
        send(D1, 32'h600, 4'b0000);
        check("mask0_we", 64'(bus.mem_we), 64'd0);
        expect_done_at("mask0_done_cycle", 1, 1);
        step();
`else
        // Mask is ignored: an all-zero mask still writes every lane
        push_vec(D2, 32'h600, 4'b0000);
        send(D2, 32'h600, 4'b0000);
        check("nomask_c1_we", 64'(bus.mem_we), 64'd1);
        expect_done_at("nomask_done_cycle", 1, 5);
        step();
`endif

        repeat (3) step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_seen), 64'(done_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
